// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels and ALU drive
// bundled between the arbiter and its clients/ALU.
interface alu_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_mode;
  logic [4*N_REQ-1:0]     req_select;
  logic [N_REQ-1:0]       req_carry;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_carry;
  logic                   rsp_compare;
  logic                   alu_mode;
  logic                   alu_carry_in;
  logic [3:0]             alu_select;
  logic [WIDTH-1:0]       alu_in_a;
  logic [WIDTH-1:0]       alu_in_b;
  logic [WIDTH-1:0]       alu_result;
  logic                   alu_carry_out;
  logic                   alu_compare;

  modport slave (
    input  req_valid, req_mode, req_select,
    input  req_carry, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_data,
    output rsp_carry, rsp_compare,
    input  rsp_ready,
    output alu_mode, alu_carry_in, alu_select,
    output alu_in_a, alu_in_b,
    input  alu_result, alu_carry_out, alu_compare
  );

  modport master (
    output req_valid, req_mode, req_select,
    output req_carry, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_data,
    input  rsp_carry, rsp_compare,
    output rsp_ready,
    input  alu_mode, alu_carry_in, alu_select,
    input  alu_in_a, alu_in_b,
    output alu_result, alu_carry_out, alu_compare
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among
// N_REQ requesters, IDLE -> EXEC -> RESP per operation.
module alu_arbiter #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_grant;
  logic [PW-1:0] w_grant;
  logic          w_any;
  int            w_idx;

  logic             r_mode;
  logic [3:0]       r_sel;
  logic             r_cin;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_cmp;

  // first pending requester at or above rr_ptr, wrapping
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_rr_ptr;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = PW'(w_idx);
      end
    end
  end

  // next state plus handshake strobes; ready suppressed in reset
  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any && rst_n) begin
          bus.req_ready[w_grant] = 1'b1;
          w_next = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        bus.rsp_valid[r_grant] = 1'b1;
        if (bus.rsp_ready[r_grant]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state, grant and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) r_grant <= w_grant;
      if (r_state == S_RESP && bus.rsp_ready[r_grant]) begin
        if (r_grant == PW'(N_REQ - 1)) r_rr_ptr <= '0;
        else r_rr_ptr <= r_grant + PW'(1);
      end
    end
  end

  // operand register, loaded only on acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
      r_sel  <= '0;
      r_cin  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_mode <= bus.req_mode[w_grant];
      r_sel  <= bus.req_select[4*w_grant +: 4];
      r_cin  <= bus.req_carry[w_grant];
      r_a    <= bus.req_a[WIDTH*w_grant +: WIDTH];
      r_b    <= bus.req_b[WIDTH*w_grant +: WIDTH];
    end
  end

  // result register, captured at the end of EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_cout <= 1'b0;
      r_cmp  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_res  <= bus.alu_result;
      r_cout <= bus.alu_carry_out;
      r_cmp  <= bus.alu_compare;
    end
  end

  assign bus.alu_mode     = r_mode;
  assign bus.alu_select   = r_sel;
  assign bus.alu_carry_in = r_cin;
  assign bus.alu_in_a     = r_a;
  assign bus.alu_in_b     = r_b;
  assign bus.rsp_data     = r_res;
  assign bus.rsp_carry    = r_cout;
  assign bus.rsp_compare  = r_cmp;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scenario tasks with a response
// scoreboard and a behavioural ALU behind the arbiter.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  logic busy;

  alu_arbiter_if #(.N_REQ(2), .WIDTH(16)) bus ();

  alu_arbiter #(.N_REQ(2), .WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [16:0] alu_sum;

  // behavioural ALU: arithmetic A+B (1001), logic ~A/A^B/A&B/A|B
  always_comb begin
    alu_sum           = '0;
    bus.alu_result    = '0;
    bus.alu_carry_out = 1'b0;
    bus.alu_compare   = (bus.alu_in_a == bus.alu_in_b);
    if (!bus.alu_mode) begin
      if (bus.alu_select == 4'b1001)
        alu_sum = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b}
                + {16'b0, bus.alu_carry_in};
      else
        alu_sum = {1'b0, bus.alu_in_a} + {16'b0, bus.alu_carry_in};
      bus.alu_result    = alu_sum[15:0];
      bus.alu_carry_out = alu_sum[16];
    end else begin
      case (bus.alu_select)
        4'b0000: bus.alu_result = ~bus.alu_in_a;
        4'b0110: bus.alu_result = bus.alu_in_a ^ bus.alu_in_b;
        4'b1011: bus.alu_result = bus.alu_in_a & bus.alu_in_b;
        4'b1110: bus.alu_result = bus.alu_in_a | bus.alu_in_b;
        default: bus.alu_result = '0;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic m,
                         input logic [3:0] s, input logic c,
                         input logic [15:0] a, input logic [15:0] b);
    bus.req_mode[i]          = m;
    bus.req_select[4*i +: 4] = s;
    bus.req_carry[i]         = c;
    bus.req_a[16*i +: 16]    = a;
    bus.req_b[16*i +: 16]    = b;
  endtask

  task automatic load_logic_pair;
    set_req(0, 1'b1, 4'b0000, 1'b0, 16'h00FF, 16'h0000);
    set_req(1, 1'b1, 4'b0110, 1'b0, 16'hFFFF, 16'h0F0F);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    set_req(0, 1'b0, 4'b0000, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'b0000, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b, want 00 00 0",
               bus.req_ready, bus.rsp_valid, busy);
    end
    checks++;
    if ({bus.alu_mode, bus.alu_carry_in, bus.alu_select,
         bus.alu_in_a, bus.alu_in_b, bus.rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h sel=%b rsp=%h, want all 0",
               bus.alu_in_a, bus.alu_in_b, bus.alu_select, bus.rsp_data);
    end
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_noready: ready=%b, want 00", bus.req_ready);
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_op;
    set_req(0, 1'b0, 4'b1001, 1'b0, 16'h1234, 16'h0001);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_accept: ready=%b, want 01", bus.req_ready);
    end
    sb.push_back('{0, 16'h1235, 1'b0});
    tick();
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 2'b00 || busy !== 1'b1 || bus.req_ready !== 2'b00 ||
        bus.alu_in_a !== 16'h1234 || bus.alu_in_b !== 16'h0001) begin
      errors++;
      $display("FAIL single_exec: rsp_valid=%b busy=%b a=%h b=%h, want 00 1 1234 0001",
               bus.rsp_valid, busy, bus.alu_in_a, bus.alu_in_b);
    end
    tick();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL single_sb: scoreboard empty, want 1 entry");
    end else begin
      e = sb.pop_front();
      if (bus.rsp_valid !== 2'(1 << e.id) || bus.rsp_data !== e.data ||
          bus.rsp_carry !== e.carry) begin
        errors++;
        $display("FAIL single_rsp: valid=%b data=%h c=%b, want %b %h %b",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_carry,
                 2'(1 << e.id), e.data, e.carry);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b, want 0 00",
               busy, bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    int g;
    rst_n = 1'b0;
    load_logic_pair();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      checks++;
      if (bus.req_ready !== 2'(1 << g)) begin
        errors++;
        $display("FAIL rr_grant%0d: ready=%b, want %b",
                 k, bus.req_ready, 2'(1 << g));
      end
      sb.push_back('{g, (g == 0) ? 16'hFF00 : 16'hF0F0, 1'b0});
      tick();
      checks++;
      if (bus.req_ready !== 2'b00 || busy !== 1'b1 || bus.rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL rr_exec%0d: ready=%b busy=%b rsp_valid=%b, want 00 1 00",
                 k, bus.req_ready, busy, bus.rsp_valid);
      end
      tick();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rr_sb%0d: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_valid !== 2'(1 << e.id) || bus.rsp_data !== e.data) begin
          errors++;
          $display("FAIL rr_rsp%0d: valid=%b data=%h, want %b %h",
                   k, bus.rsp_valid, bus.rsp_data, 2'(1 << e.id), e.data);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_pressure;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_first: ready=%b, want 01", bus.req_ready);
    end
    sb.push_back('{0, 16'hFF00, 1'b0});
    tick();
    tick();
    checks++;
    e = sb.pop_front();
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== e.data) begin
      errors++;
      $display("FAIL bp_rsp0: valid=%b data=%h, want 01 %h",
               bus.rsp_valid, bus.rsp_data, e.data);
    end
    tick();
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_grant1: ready=%b, want 10", bus.req_ready);
    end
    sb.push_back('{1, 16'hF0F0, 1'b0});
    tick();
    bus.rsp_ready = 2'b00;
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 16'hF0F0 ||
          bus.req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b busy=%b, want 10 f0f0 00 1",
                 c, bus.rsp_valid, bus.rsp_data, bus.req_ready, busy);
      end
      tick();
    end
    bus.rsp_ready = 2'b10;
    #1;
    checks++;
    e = sb.pop_front();
    if (bus.rsp_valid !== 2'(1 << e.id) || bus.rsp_data !== e.data) begin
      errors++;
      $display("FAIL bp_release: valid=%b data=%h, want %b %h",
               bus.rsp_valid, bus.rsp_data, 2'(1 << e.id), e.data);
    end
    tick();
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_next: ready=%b, want 01", bus.req_ready);
    end
    sb.push_back('{0, 16'hFF00, 1'b0});
    bus.rsp_ready = 2'b11;
    tick();
    tick();
    checks++;
    e = sb.pop_front();
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== e.data) begin
      errors++;
      $display("FAIL bp_rsp_last: valid=%b data=%h, want 01 %h",
               bus.rsp_valid, bus.rsp_data, e.data);
    end
    tick();
  endtask

  task automatic test_wrong_port;
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL wp_wrap: ready=%b, want 01", bus.req_ready);
    end
    sb.push_back('{0, 16'hFF00, 1'b0});
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b10;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.rsp_valid !== 2'b01 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wp_hold%0d: valid=%b busy=%b, want 01 1",
                 c, bus.rsp_valid, busy);
      end
      tick();
    end
    bus.rsp_ready = 2'b01;
    #1;
    checks++;
    e = sb.pop_front();
    if (bus.rsp_valid !== 2'(1 << e.id) || bus.rsp_data !== e.data) begin
      errors++;
      $display("FAIL wp_rsp: valid=%b data=%h, want %b %h",
               bus.rsp_valid, bus.rsp_data, 2'(1 << e.id), e.data);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wp_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid_op;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rst_pre_grant: ready=%b, want 10", bus.req_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || bus.alu_in_a !== 16'hFFFF) begin
      errors++;
      $display("FAIL rst_exec: busy=%b a=%h, want 1 ffff", busy, bus.alu_in_a);
    end
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || busy !== 1'b0 ||
        {bus.alu_mode, bus.alu_carry_in, bus.alu_select, bus.alu_in_a,
         bus.alu_in_b, bus.rsp_data, bus.rsp_carry, bus.rsp_compare} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: ready=%b valid=%b busy=%b a=%h rsp=%h, want all 0",
               bus.req_ready, bus.rsp_valid, busy, bus.alu_in_a, bus.rsp_data);
    end
    bus.req_valid = 2'b11;
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_quiet: valid=%b ready=%b, want 00 00",
               bus.rsp_valid, bus.req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rst_ptr: ready=%b, want 01", bus.req_ready);
    end
    sb.push_back('{0, 16'hFF00, 1'b0});
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++;
    e = sb.pop_front();
    if (bus.rsp_valid !== 2'(1 << e.id) || bus.rsp_data !== e.data) begin
      errors++;
      $display("FAIL rst_after: valid=%b data=%h, want %b %h",
               bus.rsp_valid, bus.rsp_data, 2'(1 << e.id), e.data);
    end
    tick();
  endtask

  task automatic test_carry;
    logic c_exec;
    set_req(0, 1'b0, 4'b1001, 1'b0, 16'hFFFF, 16'h0001);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL carry_accept: ready=%b, want 01", bus.req_ready);
    end
    sb.push_back('{0, 16'h0000, 1'b1});
    tick();
    bus.req_valid = 2'b00;
    #1;
    c_exec = bus.alu_carry_out;
    checks++;
    if (c_exec !== 1'b1) begin
      errors++;
      $display("FAIL carry_exec: alu carry=%b, want 1", c_exec);
    end
    tick();
    checks++;
    e = sb.pop_front();
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== e.data ||
        bus.rsp_carry !== e.carry || bus.rsp_carry !== c_exec ||
        bus.rsp_compare !== 1'b0) begin
      errors++;
      $display("FAIL carry_rsp: valid=%b data=%h c=%b cmp=%b, want 01 %h %b 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_carry,
               bus.rsp_compare, e.data, c_exec);
    end
    tick();
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL carry_end: sb=%0d busy=%b, want 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_back_pressure();
    test_wrong_port();
    test_reset_mid_op();
    test_carry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
